// File: rtl/toy_fetch_req_gen_if.sv
// ----------------------------------------------------------------------------
// toy_fetch_req_gen_if
//   Bundles every non-clock/reset signal of the fetch request generator.
//   master : the generator (drives imem requests, fq writes, fq_clear)
//   slave  : the environment (imem, fetch queue, redirect source)
//
//   Handshake rule for every *_vld/*_rdy pair: a transfer happens on a rising
//   clock edge where both vld and rdy are high. Once raised, vld and its
//   payload stay stable until that transfer, except that imem_req_vld may be
//   dropped by redirect_vld or rst.
//
//   dbg_* expose the internal counters so checkers can observe them.
// ----------------------------------------------------------------------------
interface toy_fetch_req_gen_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int INST_WIDTH      = 32,
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic                           redirect_vld;
  logic [ADDR_WIDTH-1:0]          redirect_pc;
  logic                           imem_req_vld;
  logic                           imem_req_rdy;
  logic [ADDR_WIDTH-1:0]          imem_req_addr;
  logic                           imem_rsp_vld;
  logic                           imem_rsp_rdy;
  logic [INST_WIDTH-1:0]          imem_rsp_data;
  logic                           fq_req_vld;
  logic                           fq_req_rdy;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] fq_req_pld;
  logic                           fq_clear;
  logic                           fq_pop;
  logic [CW-1:0]                  dbg_credits;
  logic [OW-1:0]                  dbg_outstanding;
  logic [OW-1:0]                  dbg_kill_cnt;

  modport master (
    input  redirect_vld, redirect_pc, imem_req_rdy, imem_rsp_vld,
           imem_rsp_data, fq_req_rdy, fq_pop,
    output imem_req_vld, imem_req_addr, imem_rsp_rdy, fq_req_vld,
           fq_req_pld, fq_clear, dbg_credits, dbg_outstanding, dbg_kill_cnt
  );

  modport slave (
    output redirect_vld, redirect_pc, imem_req_rdy, imem_rsp_vld,
           imem_rsp_data, fq_req_rdy, fq_pop,
    input  imem_req_vld, imem_req_addr, imem_rsp_rdy, fq_req_vld,
           fq_req_pld, fq_clear, dbg_credits, dbg_outstanding, dbg_kill_cnt
  );
endinterface

// File: rtl/toy_fetch_req_gen.sv
// ----------------------------------------------------------------------------
// toy_fetch_req_gen
//   Instruction fetch request generator and sole writer of the fetch queue.
//   Issues sequential imem reads, tags each response with its PC through a
//   small tag FIFO and writes {pc, inst} to the fetch queue one cycle after
//   the response. Credits mirror free queue slots, so the queue write never
//   stalls. A redirect clears the queue, restarts fetch at redirect_pc and
//   arms a kill counter that discards responses still in flight.
//
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : toy_fetch_req_gen_if.master (redirect, imem req/rsp, fq write,
//              fq_clear, fq_pop credit return, debug counters)
// ----------------------------------------------------------------------------
module toy_fetch_req_gen #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INST_WIDTH      = 32,
  parameter int                    QUEUE_DEPTH     = 8,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  toy_fetch_req_gen_if.master    bus
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ADDR_WIDTH-1:0]            pc_q, pc_d;
  logic [CW-1:0]                    credits_q, credits_d;
  logic [OW-1:0]                    outstanding_q, outstanding_d;
  logic [OW-1:0]                    kill_cnt_q, kill_cnt_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]            tag_mem_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]            tag_mem_d [MAX_OUTSTANDING];
  logic                             fq_vld_q, fq_vld_d;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] fq_pld_q, fq_pld_d;

  logic                             can_issue;
  logic                             issue;
  logic                             rsp;
  logic [CW-1:0]                    credits_after_issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    can_issue = !rst && !bus.redirect_vld && (credits_q != '0) &&
                (outstanding_q != OW'(MAX_OUTSTANDING));
    issue     = can_issue && bus.imem_req_rdy;
    rsp       = bus.imem_rsp_vld;

    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_mem_d     = tag_mem_q;
    kill_cnt_d    = kill_cnt_q;
    fq_vld_d      = fq_vld_q;
    fq_pld_d      = fq_pld_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(rsp);

    // Apply the issue first so a pop arriving with a full credit count and a
    // same-cycle issue still nets to zero.
    credits_after_issue = credits_q - CW'(issue);
    credits_d           = credits_after_issue;
    if (bus.fq_pop && (credits_after_issue != CW'(QUEUE_DEPTH))) begin
      credits_d = credits_after_issue + CW'(1);
    end

    if (issue) begin
      tag_mem_d[wr_ptr_q] = pc_q;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
      pc_d                = pc_q + ADDR_WIDTH'(4);
    end

    // The queue write is consumed whenever rdy is sampled high; a fresh
    // response in the same cycle overrides the clear below.
    if (fq_vld_q && bus.fq_req_rdy) begin
      fq_vld_d = 1'b0;
    end

    // Stale responses still pop the tag FIFO so it stays aligned with imem.
    if (rsp) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      if (kill_cnt_q != '0) begin
        kill_cnt_d = kill_cnt_q - OW'(1);
      end else if (!bus.redirect_vld) begin
        fq_vld_d = 1'b1;
        fq_pld_d = {tag_mem_q[rd_ptr_q], bus.imem_rsp_data};
      end
    end

    // Everything still in flight after this cycle's response is stale.
    if (bus.redirect_vld) begin
      pc_d       = bus.redirect_pc;
      credits_d  = CW'(QUEUE_DEPTH);
      fq_vld_d   = 1'b0;
      kill_cnt_d = outstanding_q - OW'(rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      credits_q     <= CW'(QUEUE_DEPTH);
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fq_vld_q      <= 1'b0;
      fq_pld_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fq_vld_q      <= fq_vld_d;
      fq_pld_q      <= fq_pld_d;
    end
  end

  // Tag storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign bus.imem_req_vld    = can_issue;
  assign bus.imem_req_addr   = pc_q;
  assign bus.imem_rsp_rdy    = 1'b1;
  assign bus.fq_req_vld      = fq_vld_q;
  assign bus.fq_req_pld      = fq_pld_q;
  assign bus.fq_clear        = bus.redirect_vld && !rst;
  assign bus.dbg_credits     = credits_q;
  assign bus.dbg_outstanding = outstanding_q;
  assign bus.dbg_kill_cnt    = kill_cnt_q;

  // A response with nothing outstanding means imem and this block disagree.
  a_rsp_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) bus.imem_rsp_vld |-> (outstanding_q != '0)
  );
endmodule

// File: tb/tb_toy_fetch_req_gen.sv
// ----------------------------------------------------------------------------
// tb_toy_fetch_req_gen
//   Directed bench for toy_fetch_req_gen. A second instance with a wrapping
//   RESET_PC checks PC roll-over. The environment keeps an imem pending list,
//   a fetch-queue occupancy counter and an expected fq payload queue.
// ----------------------------------------------------------------------------
module tb_toy_fetch_req_gen;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] KEY    = 32'h1234_5678;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toy_fetch_req_gen_if bus  ();
  toy_fetch_req_gen_if bus2 ();

  toy_fetch_req_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  toy_fetch_req_gen #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic b2_rdy = 1'b0;
  assign bus2.redirect_vld  = 1'b0;
  assign bus2.redirect_pc   = '0;
  assign bus2.imem_req_rdy  = b2_rdy;
  assign bus2.imem_rsp_vld  = 1'b0;
  assign bus2.imem_rsp_data = '0;
  assign bus2.fq_req_rdy    = 1'b1;
  assign bus2.fq_pop        = 1'b0;

  // fetch queue occupancy model; clear wins over a same-cycle write
  int occ = 0;
  assign bus.fq_req_rdy = (occ < 8);
  always @(posedge clk) begin
    if (rst || bus.fq_clear)
      occ <= 0;
    else
      occ <= occ + int'(bus.fq_req_vld && bus.fq_req_rdy) - int'(bus.fq_pop);
  end

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pend_q[$];
  logic [63:0] exp_q[$];
  int          kill     = 0;
  logic [31:0] exp_addr = RST_PC;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // writes to the queue are only legal while it has room
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.fq_req_vld === 1'b1)
      check("fq_rdy_when_vld", 64'(bus.fq_req_rdy), 64'd1);
  end

  // driver: one clock cycle of stimulus plus the checks for that cycle
  task automatic step(input string tag, input int idx, input bit rdy, input bit rsp_en,
                      input bit pop_en, input bit redir, input logic [31:0] rpc,
                      input bit exp_req);
    bit          rsp;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [63:0] e;
    @(negedge clk);
    rsp   = rsp_en && (pend_q.size() != 0);
    raddr = rsp ? pend_q[0] : 32'h0;
    rdata = raddr ^ KEY;
    bus.imem_req_rdy  = rdy;
    bus.imem_rsp_vld  = rsp;
    bus.imem_rsp_data = rsp ? rdata : 32'h0;
    bus.fq_pop        = pop_en && (occ > 0);
    bus.redirect_vld  = redir;
    bus.redirect_pc   = rpc;
    #1;
    check($sformatf("%s[%0d].fq_vld", tag, idx), 64'(bus.fq_req_vld), 64'(exp_q.size() != 0));
    if (bus.fq_req_vld && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d].fq_pld", tag, idx), bus.fq_req_pld, e);
    end
    check($sformatf("%s[%0d].fq_clear", tag, idx), 64'(bus.fq_clear), 64'(redir));
    check($sformatf("%s[%0d].req_vld", tag, idx), 64'(bus.imem_req_vld), 64'(exp_req));
    if (exp_req) begin
      check($sformatf("%s[%0d].req_addr", tag, idx), 64'(bus.imem_req_addr), 64'(exp_addr));
      if (rdy) begin
        pend_q.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (rsp) begin
      void'(pend_q.pop_front());
      if (!redir) begin
        if (kill > 0) kill--;
        else          exp_q.push_back({raddr, rdata});
      end
    end
    if (redir) begin
      exp_q.delete();
      kill     = pend_q.size();
      exp_addr = rpc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b2_rdy = 1'b0;
    bus.imem_req_rdy  = 1'b1;
    bus.imem_rsp_vld  = 1'b0;
    bus.imem_rsp_data = '0;
    bus.fq_pop        = 1'b0;
    bus.redirect_vld  = 1'b1;
    bus.redirect_pc   = 32'h0000_4000;
    repeat (3) @(negedge clk);
    #1;
    check("rst.req_vld", 64'(bus.imem_req_vld), 64'd0);
    check("rst.fq_clear", 64'(bus.fq_clear), 64'd0);
    check("rst.rsp_rdy", 64'(bus.imem_rsp_rdy), 64'd1);
    check("rst.fq_vld", 64'(bus.fq_req_vld), 64'd0);
    check("rst.credits", 64'(bus.dbg_credits), 64'd8);
    check("rst.outstanding", 64'(bus.dbg_outstanding), 64'd0);
    check("rst.kill_cnt", 64'(bus.dbg_kill_cnt), 64'd0);
    rst = 1'b0;
    bus.redirect_vld = 1'b0;
    bus.imem_req_rdy = 1'b0;
    #1;
    check("rst.first_vld", 64'(bus.imem_req_vld), 64'd1);
    check("rst.first_addr", 64'(bus.imem_req_addr), 64'(RST_PC));
    pend_q.delete();
    exp_q.delete();
    kill     = 0;
    exp_addr = RST_PC;
  endtask

  initial begin
    bus.imem_req_rdy  = 1'b0;
    bus.imem_rsp_vld  = 1'b0;
    bus.imem_rsp_data = '0;
    bus.fq_pop        = 1'b0;
    bus.redirect_vld  = 1'b0;
    bus.redirect_pc   = '0;

    // 1: streaming fetch, 1-cycle responses, queue drained each write
    do_reset();
    for (int i = 0; i < 10; i++) step("t1", i, 1, 1, 1, 0, 0, 1);
    check("t1.addr9", 64'(bus.imem_req_addr), 64'h8000_0024);

    // 2: no pops -> credits run out after 8 requests; one pop -> one more
    do_reset();
    for (int i = 0; i < 8; i++)   step("t2", i, 1, 1, 0, 0, 0, 1);
    for (int i = 8; i < 11; i++)  step("t2", i, 1, 1, 0, 0, 0, 0);
    check("t2.credits0", 64'(bus.dbg_credits), 64'd0);
    check("t2.outstanding0", 64'(bus.dbg_outstanding), 64'd0);
    step("t2", 11, 1, 1, 1, 0, 0, 0);
    step("t2", 12, 1, 1, 0, 0, 0, 1);
    check("t2.extra_addr", 64'(bus.imem_req_addr), 64'h8000_0020);
    for (int i = 13; i < 16; i++) step("t2", i, 1, 1, 0, 0, 0, 0);

    // 3: imem silent -> 4 requests then stall; one response -> one more
    do_reset();
    for (int i = 0; i < 4; i++) step("t3", i, 1, 0, 1, 0, 0, 1);
    step("t3", 4, 1, 0, 1, 0, 0, 0);
    step("t3", 5, 1, 0, 1, 0, 0, 0);
    check("t3.outstanding4", 64'(bus.dbg_outstanding), 64'd4);
    step("t3", 6, 1, 1, 1, 0, 0, 0);
    step("t3", 7, 1, 0, 1, 0, 0, 1);
    check("t3.next_addr", 64'(bus.imem_req_addr), 64'h8000_0010);
    step("t3", 8, 1, 0, 1, 0, 0, 0);
    step("t3", 9, 1, 0, 1, 0, 0, 0);

    // 4: redirect with 3 outstanding; their responses must be dropped
    do_reset();
    for (int i = 0; i < 3; i++) step("t4", i, 1, 0, 1, 0, 0, 1);
    step("t4", 3, 1, 0, 1, 1, 32'h0000_1000, 0);
    step("t4", 4, 1, 1, 1, 0, 0, 1);
    check("t4.kill_cnt", 64'(bus.dbg_kill_cnt), 64'd3);
    check("t4.redir_addr", 64'(bus.imem_req_addr), 64'h0000_1000);
    for (int i = 5; i < 8; i++) step("t4", i, 1, 1, 1, 0, 0, 1);
    step("t4", 8, 1, 1, 1, 0, 0, 1);
    check("t4.first_pc", 64'(bus.fq_req_pld[63:32]), 64'h0000_1000);
    step("t4", 9, 1, 1, 1, 0, 0, 1);

    // 5: PC wraps past the top of the address space; main request held
    do_reset();
    b2_rdy = 1'b1;
    check("t5.wrap_addr0", 64'(bus2.imem_req_addr), 64'hFFFF_FFFC);
    check("t5.wrap_vld0", 64'(bus2.imem_req_vld), 64'd1);
    step("t5", 0, 0, 0, 0, 0, 0, 1);
    check("t5.wrap_addr1", 64'(bus2.imem_req_addr), 64'h0000_0000);
    b2_rdy = 1'b0;
    step("t5", 1, 0, 0, 0, 0, 0, 1);
    check("t5.held_addr", 64'(bus.imem_req_addr), 64'(RST_PC));

    // 6: redirect with a same-cycle response, then a second redirect
    do_reset();
    step("t6", 0, 1, 0, 1, 0, 0, 1);
    step("t6", 1, 1, 0, 1, 0, 0, 1);
    step("t6", 2, 1, 1, 1, 1, 32'h0000_2000, 0);
    step("t6", 3, 1, 0, 1, 1, 32'h0000_3000, 0);
    check("t6.kill_after_1st", 64'(bus.dbg_kill_cnt), 64'd1);
    check("t6.credits_reload", 64'(bus.dbg_credits), 64'd8);
    step("t6", 4, 1, 1, 1, 0, 0, 1);
    check("t6.kill_after_2nd", 64'(bus.dbg_kill_cnt), 64'd1);
    check("t6.redir_addr", 64'(bus.imem_req_addr), 64'h0000_3000);
    step("t6", 5, 1, 1, 1, 0, 0, 1);
    check("t6.kill_done", 64'(bus.dbg_kill_cnt), 64'd0);
    step("t6", 6, 0, 1, 1, 0, 0, 1);
    check("t6.first_pc", 64'(bus.fq_req_pld[63:32]), 64'h0000_3000);
    for (int i = 7; i < 10; i++) step("t6", i, 0, 1, 1, 0, 0, 1);
    check("t6.credits_back", 64'(bus.dbg_credits), 64'd8);
    check("t6.outstanding_end", 64'(bus.dbg_outstanding), 64'd0);
    check("t6.queue_empty", 64'(occ), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
